sdram_arbiter: RTL and testbench

Two-port arbiter that shares one SDRAMController command interface between two requesters (e.g. a sensor write path and a readout path). It captures one requester's command, presents it to the controller until accepted, and records the owner of every accepted read in an in-order tag FIFO. That FIFO lets each returning read word be routed back to the requester that issued it. It sits between the requesters and SDRAMController, on the controller's clock.

---
 rtl/sdram_arb_pkg.sv | 15 +
 rtl/sdram_tag_fifo.sv | 66 ++++++
 rtl/sdram_arbiter.sv | 171 +++++++++++++++++
 tb/tb_sdram_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the SDRAM command arbiter.
// The widths match those of the SDRAM controller it feeds.
package sdram_arb_pkg;

    localparam int unsigned SDRAM_ADDR_W = 25;
    localparam int unsigned SDRAM_DATA_W = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } arb_state_t;

    typedef logic port_idx_t;

endpackage

// File: rtl/sdram_tag_fifo.sv
// In-order FIFO of read-owner tags, one bit wide, any depth.
// Pointers wrap explicitly, so the depth need not be a power of two.
module sdram_tag_fifo
    import sdram_arb_pkg::*;
#(
    parameter int Depth = 10,
    parameter int CntW  = $clog2(Depth + 1)
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_push,
    input  port_idx_t       i_push_tag,
    input  logic            i_pop,
    output port_idx_t       o_head,
    output logic [CntW-1:0] o_count,
    output logic            o_empty
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        return (ptr == LastPtr) ? {PtrW{1'b0}} : ptr + {{(PtrW-1){1'b0}}, 1'b1};
    endfunction

    port_idx_t       r_mem [Depth];
    logic [PtrW-1:0] r_wr_ptr;
    logic [PtrW-1:0] r_rd_ptr;
    logic [CntW-1:0] r_count;
    logic            w_do_push;
    logic            w_do_pop;

    assign o_empty   = (r_count == {CntW{1'b0}});
    assign w_do_pop  = i_pop && !o_empty;
    // A push into a full FIFO is only honoured if a pop frees a slot in the same cycle.
    assign w_do_push = i_push && ((r_count != DepthCnt) || w_do_pop);
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < Depth; i++) begin
                r_mem[i] <= 1'b0;
            end
            r_wr_ptr <= {PtrW{1'b0}};
            r_rd_ptr <= {PtrW{1'b0}};
            r_count  <= {CntW{1'b0}};
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_tag;
                r_wr_ptr        <= ptr_inc(r_wr_ptr);
            end
            if (w_do_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{(CntW-1){1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{(CntW-1){1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller command port between two
// requesters; read data is routed back through an in-order owner-tag FIFO.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int AddrWidth   = SDRAM_ADDR_W,
    parameter int DataWidth   = SDRAM_DATA_W,
    parameter int MaxInflight = 10
) (
    input  logic                               clk,
    input  logic                               rst_,
    input  logic                               p0_cmdTrigger,
    input  logic [AddrWidth-1:0]               p0_cmdAddr,
    input  logic                               p0_cmdWrite,
    input  logic [DataWidth-1:0]               p0_cmdWriteData,
    output logic                               p0_cmdReady,
    output logic [DataWidth-1:0]               p0_readData,
    output logic                               p0_readDataValid,
    input  logic                               p1_cmdTrigger,
    input  logic [AddrWidth-1:0]               p1_cmdAddr,
    input  logic                               p1_cmdWrite,
    input  logic [DataWidth-1:0]               p1_cmdWriteData,
    output logic                               p1_cmdReady,
    output logic [DataWidth-1:0]               p1_readData,
    output logic                               p1_readDataValid,
    output logic                               ctrl_cmdTrigger,
    output logic [AddrWidth-1:0]               ctrl_cmdAddr,
    output logic                               ctrl_cmdWrite,
    output logic [DataWidth-1:0]               ctrl_cmdWriteData,
    input  logic                               ctrl_cmdReady,
    input  logic [DataWidth-1:0]               ctrl_cmdReadData,
    input  logic                               ctrl_cmdReadDataValid,
    output logic                               errUnexpectedRead,
    output logic [$clog2(MaxInflight+1)-1:0]   inflightCount
);

    localparam int CntW = $clog2(MaxInflight + 1);
    localparam logic [CntW:0] MaxCnt = (CntW + 1)'(MaxInflight);

    arb_state_t           r_state, w_state_nxt;
    port_idx_t            r_owner, r_last_grant;
    logic [AddrWidth-1:0] r_addr;
    logic                 r_write;
    logic [DataWidth-1:0] r_wdata;
    logic [1:0]           r_rd_valid;
    logic [DataWidth-1:0] r_rd_data0, r_rd_data1;
    logic                 r_err;

    logic                 w_pend_read, w_room, w_capture, w_accept, w_push, w_pop, w_empty;
    logic [1:0]           w_eligible;
    port_idx_t            w_winner, w_cap_port, w_head;
    logic [CntW-1:0]      w_count;

    // A captured-but-unaccepted read already reserves a FIFO slot.
    assign w_pend_read   = (r_state == ST_ISSUE) && !r_write;
    assign w_room        = ({1'b0, w_count} + {{CntW{1'b0}}, w_pend_read}) < MaxCnt;
    assign w_eligible[0] = p0_cmdTrigger && (p0_cmdWrite || w_room);
    assign w_eligible[1] = p1_cmdTrigger && (p1_cmdWrite || w_room);
    assign w_winner      = (&w_eligible) ? ~r_last_grant : w_eligible[1];

    // State register and captured command.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_addr       <= {AddrWidth{1'b0}};
            r_write      <= 1'b0;
            r_wdata      <= {DataWidth{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_capture) begin
                r_owner      <= w_cap_port;
                r_last_grant <= w_cap_port;
                r_addr       <= w_cap_port ? p1_cmdAddr      : p0_cmdAddr;
                r_write      <= w_cap_port ? p1_cmdWrite     : p0_cmdWrite;
                r_wdata      <= w_cap_port ? p1_cmdWriteData : p0_cmdWriteData;
            end
        end
    end

    // Next state; on accept the other port may be captured back-to-back.
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_cap_port  = w_winner;
        case (r_state)
            ST_IDLE: begin
                if (|w_eligible) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ctrl_cmdReady) begin
                    if (w_eligible[~r_owner]) begin
                        w_capture   = 1'b1;
                        w_cap_port  = ~r_owner;
                        w_state_nxt = ST_ISSUE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Accept strobes and tag push.
    always_comb begin
        w_accept    = (r_state == ST_ISSUE) && ctrl_cmdReady;
        p0_cmdReady = w_accept && (r_owner == 1'b0);
        p1_cmdReady = w_accept && (r_owner == 1'b1);
        w_push      = w_accept && !r_write;
    end

    assign ctrl_cmdTrigger   = (r_state == ST_ISSUE);
    assign ctrl_cmdAddr      = r_addr;
    assign ctrl_cmdWrite     = r_write;
    assign ctrl_cmdWriteData = r_wdata;

    sdram_tag_fifo #(
        .Depth (MaxInflight),
        .CntW  (CntW)
    ) u_tag_fifo (
        .i_clk      (clk),
        .i_rst_n    (rst_),
        .i_push     (w_push),
        .i_push_tag (r_owner),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty)
    );

    assign w_pop         = ctrl_cmdReadDataValid && !w_empty;
    assign inflightCount = w_count;

    // Read-data routing and the sticky unexpected-read flag.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_rd_valid <= 2'b00;
            r_rd_data0 <= {DataWidth{1'b0}};
            r_rd_data1 <= {DataWidth{1'b0}};
            r_err      <= 1'b0;
        end else begin
            r_rd_valid <= 2'b00;
            if (w_pop) begin
                r_rd_valid[w_head] <= 1'b1;
                if (w_head) begin
                    r_rd_data1 <= ctrl_cmdReadData;
                end else begin
                    r_rd_data0 <= ctrl_cmdReadData;
                end
            end else if (ctrl_cmdReadDataValid) begin
                r_err <= 1'b1;
            end
        end
    end

    assign p0_readDataValid  = r_rd_valid[0];
    assign p1_readDataValid  = r_rd_valid[1];
    assign p0_readData       = r_rd_data0;
    assign p1_readData       = r_rd_data1;
    assign errUnexpectedRead = r_err;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter with hand-computed expectations.
module tb_sdram_arbiter;

    logic        clk = 1'b0;
    logic        rst_;
    logic        p0_cmdTrigger, p0_cmdWrite, p0_cmdReady, p0_readDataValid;
    logic [24:0] p0_cmdAddr;
    logic [15:0] p0_cmdWriteData, p0_readData;
    logic        p1_cmdTrigger, p1_cmdWrite, p1_cmdReady, p1_readDataValid;
    logic [24:0] p1_cmdAddr;
    logic [15:0] p1_cmdWriteData, p1_readData;
    logic        ctrl_cmdTrigger, ctrl_cmdWrite, ctrl_cmdReady, ctrl_cmdReadDataValid;
    logic [24:0] ctrl_cmdAddr;
    logic [15:0] ctrl_cmdWriteData, ctrl_cmdReadData;
    logic        errUnexpectedRead;
    logic [3:0]  inflightCount;

    int n_checks = 0;
    int n_errors = 0;
    logic q_owner [$];
    logic        exp_port;
    logic        cur_port;
    logic [8:0]  pat_fill;
    logic [11:0] pat_steady;

    sdram_arbiter dut (
        .clk(clk), .rst_(rst_),
        .p0_cmdTrigger(p0_cmdTrigger), .p0_cmdAddr(p0_cmdAddr), .p0_cmdWrite(p0_cmdWrite),
        .p0_cmdWriteData(p0_cmdWriteData), .p0_cmdReady(p0_cmdReady),
        .p0_readData(p0_readData), .p0_readDataValid(p0_readDataValid),
        .p1_cmdTrigger(p1_cmdTrigger), .p1_cmdAddr(p1_cmdAddr), .p1_cmdWrite(p1_cmdWrite),
        .p1_cmdWriteData(p1_cmdWriteData), .p1_cmdReady(p1_cmdReady),
        .p1_readData(p1_readData), .p1_readDataValid(p1_readDataValid),
        .ctrl_cmdTrigger(ctrl_cmdTrigger), .ctrl_cmdAddr(ctrl_cmdAddr),
        .ctrl_cmdWrite(ctrl_cmdWrite), .ctrl_cmdWriteData(ctrl_cmdWriteData),
        .ctrl_cmdReady(ctrl_cmdReady), .ctrl_cmdReadData(ctrl_cmdReadData),
        .ctrl_cmdReadDataValid(ctrl_cmdReadDataValid),
        .errUnexpectedRead(errUnexpectedRead), .inflightCount(inflightCount)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_ = 1'b0;
        p0_cmdTrigger = 1'b0; p0_cmdAddr = 25'h0; p0_cmdWrite = 1'b0; p0_cmdWriteData = 16'h0;
        p1_cmdTrigger = 1'b0; p1_cmdAddr = 25'h0; p1_cmdWrite = 1'b0; p1_cmdWriteData = 16'h0;
        ctrl_cmdReady = 1'b0; ctrl_cmdReadData = 16'h0; ctrl_cmdReadDataValid = 1'b0;
        tick();
        tick();
        rst_ = 1'b1;
    endtask

    // Issue one read from a port and wait (bounded) for its accept.
    task automatic issue_read(input logic port, input logic [24:0] addr);
        logic got;
        got = 1'b0;
        if (port) begin
            p1_cmdAddr = addr; p1_cmdWrite = 1'b0; p1_cmdTrigger = 1'b1;
        end else begin
            p0_cmdAddr = addr; p0_cmdWrite = 1'b0; p0_cmdTrigger = 1'b1;
        end
        for (int i = 0; i < 8 && !got; i++) begin
            tick();
            if ((port ? p1_cmdReady : p0_cmdReady) === 1'b1) got = 1'b1;
        end
        check_val("issue_read_accept", {31'h0, got}, 32'h1);
        tick();
        p0_cmdTrigger = 1'b0;
        p1_cmdTrigger = 1'b0;
        q_owner.push_back(port);
    endtask

    initial begin
        int acc;
        // Reset state
        apply_reset();
        rst_ = 1'b0;
        #1;
        check_val("rst_trigger", {31'h0, ctrl_cmdTrigger}, 32'h0);
        check_val("rst_inflight", {28'h0, inflightCount}, 32'h0);
        check_val("rst_err", {31'h0, errUnexpectedRead}, 32'h0);
        check_val("rst_rdvalid", {30'h0, p1_readDataValid, p0_readDataValid}, 32'h0);
        check_val("rst_rddata", {p1_readData, p0_readData}, 32'h0);
        tick();
        rst_ = 1'b1;

        // Single write from port 0
        p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b1; p0_cmdAddr = 25'h10; p0_cmdWriteData = 16'hBEEF;
        tick();
        check_val("wr_trigger", {31'h0, ctrl_cmdTrigger}, 32'h1);
        check_val("wr_addr", {7'h0, ctrl_cmdAddr}, 32'h10);
        check_val("wr_write", {31'h0, ctrl_cmdWrite}, 32'h1);
        check_val("wr_data", {16'h0, ctrl_cmdWriteData}, 32'hBEEF);
        check_val("wr_ready_low", {30'h0, p1_cmdReady, p0_cmdReady}, 32'h0);
        tick();
        check_val("wr_hold_addr", {7'h0, ctrl_cmdAddr}, 32'h10);
        ctrl_cmdReady = 1'b1;
        #1;
        check_val("wr_ready_pulse", {30'h0, p1_cmdReady, p0_cmdReady}, 32'h1);
        tick();
        p0_cmdTrigger = 1'b0;
        ctrl_cmdReady = 1'b0;
        #1;
        check_val("wr_idle", {31'h0, ctrl_cmdTrigger}, 32'h0);
        check_val("wr_inflight", {28'h0, inflightCount}, 32'h0);

        // Both ports read every cycle: accepts alternate 0,1,0,1,...
        apply_reset();
        p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b0; p0_cmdAddr = 25'h100;
        p1_cmdTrigger = 1'b1; p1_cmdWrite = 1'b0; p1_cmdAddr = 25'h200;
        ctrl_cmdReady = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            check_val("alt_ready", {30'h0, p1_cmdReady, p0_cmdReady}, (i % 2) ? 32'h2 : 32'h1);
            check_val("alt_addr", {7'h0, ctrl_cmdAddr}, (i % 2) ? 32'h200 : 32'h100);
            if (i == 5) begin
                p0_cmdTrigger = 1'b0;
                p1_cmdTrigger = 1'b0;
            end
            tick();
        end
        ctrl_cmdReady = 1'b0;
        check_val("alt_idle", {31'h0, ctrl_cmdTrigger}, 32'h0);
        check_val("alt_inflight", {28'h0, inflightCount}, 32'h6);
        for (int i = 0; i < 6; i++) begin
            ctrl_cmdReadDataValid = 1'b1;
            ctrl_cmdReadData = 16'hA000 + 16'(i);
            tick();
            check_val("alt_rdvalid", {30'h0, p1_readDataValid, p0_readDataValid}, (i % 2) ? 32'h2 : 32'h1);
            check_val("alt_rddata", {16'h0, (i % 2) ? p1_readData : p0_readData}, 32'hA000 + i);
        end
        ctrl_cmdReadDataValid = 1'b0;
        tick();
        check_val("alt_rdquiet", {30'h0, p1_readDataValid, p0_readDataValid}, 32'h0);
        check_val("alt_drained", {28'h0, inflightCount}, 32'h0);

        // Port 1 fills the FIFO; the 11th read stalls, a port 0 write still goes
        apply_reset();
        p1_cmdTrigger = 1'b1; p1_cmdWrite = 1'b0; p1_cmdAddr = 25'h77;
        ctrl_cmdReady = 1'b1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (p1_cmdReady === 1'b1) acc++;
        end
        check_val("full_accepts", acc, 32'd10);
        check_val("full_inflight", {28'h0, inflightCount}, 32'd10);
        check_val("full_stalled", {31'h0, ctrl_cmdTrigger}, 32'h0);
        p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b1; p0_cmdAddr = 25'h55; p0_cmdWriteData = 16'h1111;
        tick();
        check_val("full_wr_addr", {7'h0, ctrl_cmdAddr}, 32'h55);
        check_val("full_wr_ready", {30'h0, p1_cmdReady, p0_cmdReady}, 32'h1);
        tick();
        p0_cmdTrigger = 1'b0;
        check_val("full_wr_inflight", {28'h0, inflightCount}, 32'd10);
        ctrl_cmdReadDataValid = 1'b1; ctrl_cmdReadData = 16'h1234;
        tick();
        ctrl_cmdReadDataValid = 1'b0;
        check_val("full_pop_valid", {30'h0, p1_readDataValid, p0_readDataValid}, 32'h2);
        check_val("full_pop_data", {16'h0, p1_readData}, 32'h1234);
        check_val("full_pop_inflight", {28'h0, inflightCount}, 32'd9);
        tick();
        check_val("full_resume_ready", {30'h0, p1_cmdReady, p0_cmdReady}, 32'h2);
        check_val("full_resume_write", {31'h0, ctrl_cmdWrite}, 32'h0);
        tick();
        p1_cmdTrigger = 1'b0;
        check_val("full_resume_inflight", {28'h0, inflightCount}, 32'd10);

        // Simultaneous push and pop at occupancy 9 across the pointer wrap
        apply_reset();
        q_owner.delete();
        ctrl_cmdReady = 1'b1;
        pat_fill   = 9'b010110100;
        pat_steady = 12'b101100101101;
        for (int i = 0; i < 9; i++) begin
            issue_read(pat_fill[i], 25'h300 + 25'(i));
        end
        check_val("wrap_fill", {28'h0, inflightCount}, 32'd9);
        for (int j = 0; j < 12; j++) begin
            cur_port = pat_steady[j];
            if (cur_port) begin
                p1_cmdTrigger = 1'b1; p1_cmdWrite = 1'b0; p1_cmdAddr = 25'h400 + 25'(j);
            end else begin
                p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b0; p0_cmdAddr = 25'h400 + 25'(j);
            end
            tick();
            ctrl_cmdReadDataValid = 1'b1;
            ctrl_cmdReadData = 16'hC000 + 16'(j);
            tick();
            p0_cmdTrigger = 1'b0;
            p1_cmdTrigger = 1'b0;
            ctrl_cmdReadDataValid = 1'b0;
            exp_port = q_owner.pop_front();
            q_owner.push_back(cur_port);
            check_val("wrap_route", {30'h0, p1_readDataValid, p0_readDataValid}, exp_port ? 32'h2 : 32'h1);
            check_val("wrap_data", {16'h0, exp_port ? p1_readData : p0_readData}, 32'hC000 + j);
            check_val("wrap_occupancy", {28'h0, inflightCount}, 32'd9);
        end
        ctrl_cmdReady = 1'b0;

        // Read data with an empty FIFO
        apply_reset();
        ctrl_cmdReadDataValid = 1'b1; ctrl_cmdReadData = 16'hDEAD;
        tick();
        ctrl_cmdReadDataValid = 1'b0;
        check_val("unexp_err", {31'h0, errUnexpectedRead}, 32'h1);
        check_val("unexp_novalid", {30'h0, p1_readDataValid, p0_readDataValid}, 32'h0);
        tick(); tick(); tick();
        check_val("unexp_sticky", {31'h0, errUnexpectedRead}, 32'h1);
        check_val("unexp_inflight", {28'h0, inflightCount}, 32'h0);
        rst_ = 1'b0;
        #1;
        check_val("unexp_cleared", {31'h0, errUnexpectedRead}, 32'h0);

        // Reset mid-ISSUE with 3 reads in flight
        apply_reset();
        ctrl_cmdReady = 1'b1;
        for (int i = 0; i < 3; i++) issue_read(1'b0, 25'h500 + 25'(i));
        check_val("mid_inflight", {28'h0, inflightCount}, 32'd3);
        ctrl_cmdReady = 1'b0;
        p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b0; p0_cmdAddr = 25'h510;
        tick();
        check_val("mid_issue", {31'h0, ctrl_cmdTrigger}, 32'h1);
        #2;
        rst_ = 1'b0;
        #1;
        check_val("mid_rst_trigger", {31'h0, ctrl_cmdTrigger}, 32'h0);
        check_val("mid_rst_inflight", {28'h0, inflightCount}, 32'h0);
        tick();
        rst_ = 1'b1;
        p0_cmdTrigger = 1'b1; p0_cmdWrite = 1'b1; p0_cmdAddr = 25'h501;
        p1_cmdTrigger = 1'b1; p1_cmdWrite = 1'b1; p1_cmdAddr = 25'h602;
        ctrl_cmdReady = 1'b1;
        tick();
        check_val("post_rst_tie", {30'h0, p1_cmdReady, p0_cmdReady}, 32'h1);
        check_val("post_rst_addr", {7'h0, ctrl_cmdAddr}, 32'h501);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
